edge_event_capture: RTL and testbench

//  Multi-channel edge detector: successor to the single-bit rising-edge block.
//  Per channel: optional input synchroniser, stability filter, runtime mode
//  (off/rise/fall/both), one-cycle registered event pulse, sticky pending flag.

---
 rtl/edge_event_capture_pkg.sv | 16 +
 rtl/edge_event_capture_if.sv | 49 ++++
 rtl/edge_event_ch.sv | 149 ++++++++++++++
 rtl/edge_event_capture.sv | 75 +++++++
 tb/tb_edge_event_capture.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/edge_event_capture_pkg.sv
// Package edge_event_pkg: shared types and constants for the multi-channel
// edge event capture block.
//   MODE_W       width of one channel's mode field in i_mode
//   edge_mode_e  per-channel edge selection (off / rise / fall / both)
package edge_event_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_e;

endpackage

// File: rtl/edge_event_capture_if.sv
// edge_event_capture_if: groups the channel-vector signals of edge_event_capture.
//   i_data    raw channel inputs (NUM_CH)
//   i_mode    per-channel mode, channel c at [2c+1:2c]
//   i_clr     write-1-to-clear strobe per channel
//   o_pulse   one-cycle qualified edge pulses
//   o_pending sticky event flags
//   o_irq     OR of all pending flags, registered
//   o_cnt     per-channel event counters, present only with EDGE_EVENT_CNT_EN
// slave modport is the design side, master modport the driver side.
interface edge_event_capture_if
    import edge_event_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]        i_data;
    logic [MODE_W*NUM_CH-1:0] i_mode;
    logic [NUM_CH-1:0]        i_clr;
    logic [NUM_CH-1:0]        o_pulse;
    logic [NUM_CH-1:0]        o_pending;
    logic                     o_irq;
`ifdef EDGE_EVENT_CNT_EN
    logic [NUM_CH*CNT_W-1:0]  o_cnt;
`endif

    modport slave (
        input  i_data,
        input  i_mode,
        input  i_clr,
`ifdef EDGE_EVENT_CNT_EN
        output o_cnt,
`endif
        output o_pulse,
        output o_pending,
        output o_irq
    );

    modport master (
        output i_data,
        output i_mode,
        output i_clr,
`ifdef EDGE_EVENT_CNT_EN
        input  o_cnt,
`endif
        input  o_pulse,
        input  o_pending,
        input  o_irq
    );
endinterface

// File: rtl/edge_event_ch.sv
// edge_event_ch: one channel of the edge event capture block.
// Synchroniser (SYNC_STAGES flops, bypassed when 0), stability filter
// (a new level must persist FILTER_CYCLES cycles before it is accepted),
// mode-qualified edge detection, registered pulse and sticky pending flag.
// Optional saturating event counter when EDGE_EVENT_CNT_EN is defined.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_data           raw channel input
//   i_mode           edge selection for this channel
//   i_clr            clear strobe for pending flag (and counter)
//   o_pulse          one-cycle pulse per qualified edge
//   o_pending        sticky event flag
//   o_pending_next   next-state of the pending flag, for the shared irq flop
//   o_cnt            event counter (EDGE_EVENT_CNT_EN only)
module edge_event_ch
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_data,
    input  edge_mode_e i_mode,
    input  logic       i_clr,
`ifdef EDGE_EVENT_CNT_EN
    output logic [CNT_W-1:0] o_cnt,
`endif
    output logic       o_pulse,
    output logic       o_pending,
    output logic       o_pending_next
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);

    logic s_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_s = i_data;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            // Shift the raw input in at bit 0; the top bit is the synchronised level.
            always_comb begin
                sync_d = (sync_q << 1'b1) | SYNC_STAGES'(i_data);
            end

            // Synchroniser chain flops.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sync_q <= {SYNC_STAGES{1'b0}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic          lvl_q, lvl_d;
    logic [FW-1:0] f_q, f_d;
    logic          pulse_q, pulse_d;
    logic          pending_q, pending_d;
    logic          accept_s, rise_s, fall_s, q_s;

    // Filter: count consecutive cycles the synchronised level disagrees with the
    // accepted level; accept on the FILTER_CYCLES-th such cycle.
    always_comb begin
        lvl_d    = lvl_q;
        f_d      = f_q;
        accept_s = 1'b0;
        if (s_s == lvl_q) begin
            f_d = {FW{1'b0}};
        end else if (f_q == F_LAST) begin
            accept_s = 1'b1;
            lvl_d    = s_s;
            f_d      = {FW{1'b0}};
        end else begin
            f_d = f_q + FW'(1);
        end
    end

    // Edge qualification by mode, then pulse and sticky pending next-state.
    // An edge in the same cycle as a clear wins, so no event is lost.
    always_comb begin
        rise_s = accept_s & s_s;
        fall_s = accept_s & ~s_s;
        case (i_mode)
            EDGE_OFF:  q_s = 1'b0;
            EDGE_RISE: q_s = rise_s;
            EDGE_FALL: q_s = fall_s;
            EDGE_BOTH: q_s = rise_s | fall_s;
            default:   q_s = 1'b0;
        endcase
        pulse_d   = q_s;
        pending_d = q_s | (pending_q & ~i_clr);
    end

    // Level, filter, pulse and pending flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lvl_q     <= 1'b0;
            f_q       <= {FW{1'b0}};
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            lvl_q     <= lvl_d;
            f_q       <= f_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
        end
    end

    assign o_pulse        = pulse_q;
    assign o_pending      = pending_q;
    assign o_pending_next = pending_d;

`ifdef EDGE_EVENT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating event counter; a clear coinciding with an edge leaves a count of 1.
    always_comb begin
        if (i_clr) begin
            cnt_d = q_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (q_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Event counter flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
`endif

endmodule

// File: rtl/edge_event_capture.sv
// edge_event_capture: multi-channel edge detector with per-channel
// synchroniser, stability filter, runtime mode, event pulse and sticky flag.
// Optional feature macro: EDGE_EVENT_CNT_EN adds per-channel saturating
// event counters on o_cnt; without it o_cnt does not exist.
// Ports:
//   i_clk    single clock, posedge
//   i_rst_n  asynchronous active-low reset
//   bus      edge_event_capture_if.slave: i_data, i_mode, i_clr in;
//            o_pulse, o_pending, o_irq (and o_cnt) out
module edge_event_capture
    import edge_event_pkg::*;
#(
    parameter int NUM_CH        = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    edge_event_capture_if.slave bus
);

    logic [NUM_CH-1:0] pulse_s;
    logic [NUM_CH-1:0] pending_s;
    logic [NUM_CH-1:0] pending_next_s;
`ifdef EDGE_EVENT_CNT_EN
    logic [NUM_CH*CNT_W-1:0] cnt_s;
`endif

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            edge_event_ch #(
                .SYNC_STAGES   (SYNC_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES),
                .CNT_W         (CNT_W)
            ) u_ch (
                .i_clk          (i_clk),
                .i_rst_n        (i_rst_n),
                .i_data         (bus.i_data[c]),
                .i_mode         (edge_mode_e'(bus.i_mode[MODE_W*c +: MODE_W])),
                .i_clr          (bus.i_clr[c]),
`ifdef EDGE_EVENT_CNT_EN
                .o_cnt          (cnt_s[CNT_W*c +: CNT_W]),
`endif
                .o_pulse        (pulse_s[c]),
                .o_pending      (pending_s[c]),
                .o_pending_next (pending_next_s[c])
            );
        end
    endgenerate

    logic irq_q, irq_d;

    // irq follows the next pending state so it rises with o_pending, not a cycle later.
    always_comb begin
        irq_d = |pending_next_s;
    end

    // Interrupt flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.o_pulse   = pulse_s;
    assign bus.o_pending = pending_s;
    assign bus.o_irq     = irq_q;
`ifdef EDGE_EVENT_CNT_EN
    assign bus.o_cnt     = cnt_s;
`endif

endmodule

// File: tb/tb_edge_event_capture.sv
// Bench for edge_event_capture: two instances (2 sync stages / no filter, and
// no synchroniser / 4-cycle filter) share one stimulus stream. A reference
// model built from the input history (delayed samples, window of the last
// FILTER_CYCLES samples) predicts pulses, pending, irq and counters.
module tb_edge_event_capture;
    import edge_event_pkg::*;

    localparam int NCH = 8;
    localparam int CW  = 4;
    localparam int SA  = 2;
    localparam int FA  = 1;
    localparam int SB  = 0;
    localparam int FB  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]   data_v = '0;
    logic [2*NCH-1:0] mode_v = '0;
    logic [NCH-1:0]   clr_v  = '0;

    edge_event_capture_if #(.NUM_CH(NCH), .CNT_W(CW)) bus_a ();
    edge_event_capture_if #(.NUM_CH(NCH), .CNT_W(CW)) bus_b ();

    assign bus_a.i_data = data_v;
    assign bus_a.i_mode = mode_v;
    assign bus_a.i_clr  = clr_v;
    assign bus_b.i_data = data_v;
    assign bus_b.i_mode = mode_v;
    assign bus_b.i_clr  = clr_v;

    edge_event_capture #(.NUM_CH(NCH), .SYNC_STAGES(SA), .FILTER_CYCLES(FA), .CNT_W(CW))
        dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
    edge_event_capture #(.NUM_CH(NCH), .SYNC_STAGES(SB), .FILTER_CYCLES(FB), .CNT_W(CW))
        dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state, index 0 = dut_a, 1 = dut_b
    logic [NCH-1:0] raw_hist[$];
    bit             lvl_m   [2][NCH];
    int             cnt_m   [2][NCH];
    logic [NCH-1:0] pulse_m [2];
    logic [NCH-1:0] pend_m  [2];
    logic           irq_m   [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit s_at(int j, int sync, int c);
        if (j - sync < 1) return 1'b0;
        return raw_hist[j - sync - 1][c];
    endfunction

    task automatic model_reset();
        raw_hist.delete();
        for (int d = 0; d < 2; d++) begin
            pulse_m[d] = '0;
            pend_m[d]  = '0;
            irq_m[d]   = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                lvl_m[d][c] = 1'b0;
                cnt_m[d][c] = 0;
            end
        end
    endtask

    task automatic model_step();
        int k;
        raw_hist.push_back(data_v);
        k = raw_hist.size();
        for (int d = 0; d < 2; d++) begin
            int sync = (d == 0) ? SA : SB;
            int filt = (d == 0) ? FA : FB;
            for (int c = 0; c < NCH; c++) begin
                bit acc, rise, fall, q;
                acc = (k >= filt);
                for (int j = k - filt + 1; j <= k; j++)
                    if (j >= 1 && s_at(j, sync, c) == lvl_m[d][c]) acc = 1'b0;
                rise = acc && !lvl_m[d][c];
                fall = acc && lvl_m[d][c];
                if (acc) lvl_m[d][c] = !lvl_m[d][c];
                q = (rise && mode_v[2*c]) || (fall && mode_v[2*c+1]);
                pulse_m[d][c] = q;
                if (clr_v[c]) cnt_m[d][c] = q ? 1 : 0;
                else if (q && cnt_m[d][c] < (1 << CW) - 1) cnt_m[d][c]++;
                pend_m[d][c] = q || (pend_m[d][c] && !clr_v[c]);
            end
            irq_m[d] = |pend_m[d];
        end
    endtask

    task automatic compare();
        logic [31:0] ea, eb;
        check_val("a_pulse",   32'(bus_a.o_pulse),   32'(pulse_m[0]));
        check_val("a_pending", 32'(bus_a.o_pending), 32'(pend_m[0]));
        check_val("a_irq",     32'(bus_a.o_irq),     32'(irq_m[0]));
        check_val("b_pulse",   32'(bus_b.o_pulse),   32'(pulse_m[1]));
        check_val("b_pending", 32'(bus_b.o_pending), 32'(pend_m[1]));
        check_val("b_irq",     32'(bus_b.o_irq),     32'(irq_m[1]));
        ea = '0;
        eb = '0;
        for (int c = 0; c < NCH; c++) begin
            ea[c*CW +: CW] = CW'(cnt_m[0][c]);
            eb[c*CW +: CW] = CW'(cnt_m[1][c]);
        end
`ifdef EDGE_EVENT_CNT_EN
        check_val("a_cnt", 32'(bus_a.o_cnt), ea);
        check_val("b_cnt", 32'(bus_b.o_cnt), eb);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat_a, lat_b;

        // reset state
        mode_v = 16'h5555;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) step();

        // latency from an input step to the pulse, all channels RISE
        data_v[0] = 1'b1;
        lat_a = 0;
        lat_b = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (lat_a == 0 && bus_a.o_pulse[0]) lat_a = i;
            if (lat_b == 0 && bus_b.o_pulse[0]) lat_b = i;
        end
        check_val("lat_a", 32'(lat_a), 32'(SA + FA));
        check_val("lat_b", 32'(lat_b), 32'(SB + FB));

        // clear coinciding with a new edge keeps pending; a lone clear drops it
        mode_v = 16'h5557;
        data_v[0] = 1'b0;
        step();
        step();
        clr_v[0] = 1'b1;
        step();
        check_val("t4_pend_keep", 32'(bus_a.o_pending[0]), 32'd1);
        step();
        clr_v[0] = 1'b0;
        check_val("t4_pend_clr", 32'(bus_a.o_pending[0]), 32'd0);
        check_val("t4_irq_clr",  32'(bus_a.o_irq), 32'd0);
        repeat (6) step();

        // inputs high through reset release: every RISE channel pulses once
        mode_v = 16'h5555;
        data_v = '1;
        do_reset();
        repeat (10) step();
        check_val("t5_pend_all", 32'(bus_a.o_pending), 32'hFF);

        // 20 rising edges on channel 0 saturate the 4-bit counter
        do_reset();
        data_v = '0;
        repeat (6) step();
        for (int i = 0; i < 40; i++) begin
            data_v[0] = ~data_v[0];
            step();
        end
        repeat (6) step();
`ifdef EDGE_EVENT_CNT_EN
        check_val("t6_sat", 32'(bus_a.o_cnt[CW-1:0]), 32'd15);
`endif
        clr_v[0] = 1'b1;
        step();
        clr_v[0] = 1'b0;
`ifdef EDGE_EVENT_CNT_EN
        check_val("t6_clr", 32'(bus_a.o_cnt[CW-1:0]), 32'd0);
`endif

        // randomized traffic with glitches, mode changes, clears and a mid-burst reset
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) data_v = data_v ^ NCH'($urandom);
            if ($urandom_range(0, 31) == 0) mode_v = 16'($urandom);
            clr_v = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
            if (i == 400) do_reset();
            step();
        end
        clr_v = '0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
